boot_mem_arbiter: RTL

Owns the single main-memory port and sequences system boot. During boot the program loader has exclusive write access and the CPU is held in reset. Once loading completes and a settle delay expires, the block releases the CPU. It then arbitrates the memory port between the CPU instruction-fetch and data requesters, with a 1-cycle read-return path.

---
 rtl/boot_mem_arbiter_pkg.sv | 24 ++
 rtl/boot_mem_arbiter_rr_arb2.sv | 40 ++++
 rtl/boot_mem_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/boot_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// boot_mem_arbiter_pkg
// Shared definitions for the boot sequencer / memory-port arbiter:
//   - boot_state_t : BOOT / SETTLE / RUN encodings (3 is illegal)
//   - owner_t      : which requester owns the read returning next cycle
//   - DEFAULT_RELEASE_DLY : default SETTLE length in cycles
// ---------------------------------------------------------------------------
package boot_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } boot_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int DEFAULT_RELEASE_DLY = 4;

endpackage

// File: rtl/boot_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester alternating arbiter. A lone requester is always granted.
// When both request, the one that lost the previous contended cycle wins.
// The pointer only moves on contended cycles and resets fetch-preferred.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_req   : request vector, [0]=fetch, [1]=data
//   o_gnt   : one-hot grant, combinational
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_prefer_d;

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_prefer_d ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    // After fetch wins a contended cycle, data is preferred next, and vice versa.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prefer_d <= 1'b0;
        end else if (i_req == 2'b11) begin
            r_prefer_d <= o_gnt[0];
        end
    end

endmodule

// File: rtl/boot_mem_arbiter.sv
// ---------------------------------------------------------------------------
// boot_mem_arbiter
// Owns the single main-memory port. In BOOT the loader writes memory
// directly while the CPU is held in reset. After ldr_done, SETTLE waits
// RELEASE_DLY cycles, then RUN releases the CPU and arbitrates the port
// between instruction fetch and data requesters with a 1-cycle read return.
// Ports:
//   i_clk, i_rst_n                : clock, async active-low reset
//   i_ldr_addr/wdata/we, i_ldr_done : program loader interface
//   i_if_req/addr, o_if_gnt/rvalid/rdata : fetch read port
//   i_d_req/we/addr/wdata, o_d_gnt/rvalid/rdata : data port
//   o_mem_addr/wdata/we/re, i_mem_rdata : memory port (1-cycle read latency)
//   o_cpu_rst_n    : registered CPU reset, high only in RUN
//   o_boot_state   : current state for debug
//   o_ldr_late_err : sticky, loader write seen after BOOT
// ---------------------------------------------------------------------------
module boot_mem_arbiter
    import boot_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RELEASE_DLY = DEFAULT_RELEASE_DLY
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_ldr_addr,
    input  logic [DATA_W-1:0] i_ldr_wdata,
    input  logic              i_ldr_we,
    input  logic              i_ldr_done,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_cpu_rst_n,
    output logic [1:0]        o_boot_state,
    output logic              o_ldr_late_err
);

    localparam logic [7:0] LP_CNT_INIT = 8'(RELEASE_DLY - 1);

    boot_state_t       r_state;
    logic [7:0]        r_cnt;
    logic              r_cpu_rst_n;
    logic              r_late_err;
    owner_t            r_rd_owner;
    logic [ADDR_W-1:0] r_last_addr;

    logic              w_run;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;
    logic              w_mem_re;

    assign w_run = (r_state == ST_RUN);

    // Requests are masked outside RUN so the arbiter pointer cannot move
    // during boot.
    assign w_req = {i_d_req & w_run, i_if_req & w_run};

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    // Memory port mux. Without an access the address holds its last value.
    always_comb begin
        w_mem_addr  = r_last_addr;
        w_mem_wdata = i_d_wdata;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_mem_addr  = i_ldr_addr;
                w_mem_wdata = i_ldr_wdata;
                w_mem_we    = i_ldr_we;
            end
            ST_RUN: begin
                if (w_gnt[0]) begin
                    w_mem_addr = i_if_addr;
                    w_mem_re   = 1'b1;
                end else if (w_gnt[1]) begin
                    w_mem_addr = i_d_addr;
                    w_mem_we   = i_d_we;
                    w_mem_re   = ~i_d_we;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_addr <= '0;
        end else begin
            r_last_addr <= w_mem_addr;
        end
    end

    // Boot FSM. cpu_rst_n is registered so it rises on the edge entering RUN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_BOOT;
            r_cnt       <= 8'd0;
            r_cpu_rst_n <= 1'b0;
            r_late_err  <= 1'b0;
        end else begin
            r_cpu_rst_n <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    if (i_ldr_done) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= LP_CNT_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (i_ldr_we) begin
                        r_late_err <= 1'b1;
                    end
                    if (r_cnt == 8'd0) begin
                        r_state     <= ST_RUN;
                        r_cpu_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_RUN: begin
                    r_cpu_rst_n <= 1'b1;
                    if (i_ldr_we) begin
                        r_late_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    // Remember who owns the read whose data arrives next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_owner <= OWN_NONE;
        end else if (w_gnt[0]) begin
            r_rd_owner <= OWN_IF;
        end else if (w_gnt[1] && !i_d_we) begin
            r_rd_owner <= OWN_D;
        end else begin
            r_rd_owner <= OWN_NONE;
        end
    end

    assign o_if_gnt       = w_gnt[0];
    assign o_d_gnt        = w_gnt[1];
    assign o_if_rvalid    = (r_rd_owner == OWN_IF);
    assign o_d_rvalid     = (r_rd_owner == OWN_D);
    assign o_if_rdata     = i_mem_rdata;
    assign o_d_rdata      = i_mem_rdata;
    assign o_mem_addr     = w_mem_addr;
    assign o_mem_wdata    = w_mem_wdata;
    assign o_mem_we       = w_mem_we;
    assign o_mem_re       = w_mem_re;
    assign o_cpu_rst_n    = r_cpu_rst_n;
    assign o_boot_state   = r_state;
    assign o_ldr_late_err = r_late_err;

endmodule
